operand_sign_splitter: RTL

Front-end stage of the PPU datapath. It takes two raw posit operands and an op code, splits each operand into sign, magnitude and special-case flags, and produces the per-operand signs consumed by the downstream sign-decision stage. For ADD/SUB it applies the SUB sign flip and orders the operands so that operand 1 has the larger magnitude; the result sign of ADD/SUB is therefore always sign1. It has valid/ready handshakes on both sides and a one-entry skid buffer.

---
 rtl/operand_sign_splitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/operand_sign_splitter.sv
// rtl/operand_sign_splitter.sv - posit operand sign/magnitude split with ADD/SUB ordering and skid buffer

package ppu_pkg;
    localparam int OP_SIZE = 3;
    localparam logic [OP_SIZE-1:0] OP_ADD = 3'd0;
    localparam logic [OP_SIZE-1:0] OP_SUB = 3'd1;
    localparam logic [OP_SIZE-1:0] OP_MUL = 3'd2;
    localparam logic [OP_SIZE-1:0] OP_DIV = 3'd3;
endpackage

module operand_sign_splitter
    import ppu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       p1,
    input  logic [N-1:0]       p2,
    input  logic [OP_SIZE-1:0] op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign1,
    output logic               sign2,
    output logic [N-2:0]       mag1,
    output logic [N-2:0]       mag2,
    output logic               zero1,
    output logic               zero2,
    output logic               nar1,
    output logic               nar2,
    output logic               swapped,
    output logic [OP_SIZE-1:0] op_out
);

    typedef struct packed {
        logic               sign1;
        logic               sign2;
        logic [N-2:0]       mag1;
        logic [N-2:0]       mag2;
        logic               zero1;
        logic               zero2;
        logic               nar1;
        logic               nar2;
        logic               swapped;
        logic [OP_SIZE-1:0] op;
    } entry_t;

    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] neg1, neg2;
    logic         z1, z2, n1, n2;
    logic         s1, s2, s2_eff;
    logic [N-2:0] m1, m2;
    logic         is_addsub, do_swap;
    entry_t       new_e;

    // Two's-complement negation of the NaR pattern yields itself, so its
    // magnitude bits come out zero without a special case.
    always_comb begin
        neg1      = ~p1 + ONE;
        neg2      = ~p2 + ONE;
        z1        = (p1 == '0);
        z2        = (p2 == '0);
        n1        = (p1 == NAR_PAT);
        n2        = (p2 == NAR_PAT);
        s1        = p1[N-1] & ~n1;
        s2        = p2[N-1] & ~n2;
        m1        = p1[N-1] ? neg1[N-2:0] : p1[N-2:0];
        m2        = p2[N-1] ? neg2[N-2:0] : p2[N-2:0];
        is_addsub = (op == OP_ADD) || (op == OP_SUB);
        s2_eff    = ((op == OP_SUB) && !z2 && !n2) ? ~s2 : s2;
        do_swap   = is_addsub && (m2 > m1);

        new_e         = '0;
        new_e.op      = op;
        new_e.swapped = do_swap;
        if (do_swap) begin
            new_e.sign1 = s2_eff;
            new_e.mag1  = m2;
            new_e.zero1 = z2;
            new_e.nar1  = n2;
            new_e.sign2 = s1;
            new_e.mag2  = m1;
            new_e.zero2 = z1;
            new_e.nar2  = n1;
        end else begin
            new_e.sign1 = s1;
            new_e.mag1  = m1;
            new_e.zero1 = z1;
            new_e.nar1  = n1;
            new_e.sign2 = s2_eff;
            new_e.mag2  = m2;
            new_e.zero2 = z2;
            new_e.nar2  = n2;
        end
    end

    entry_t or_q, sr_q;
    logic   or_valid, sr_valid, in_ready_q;
    logic   accept, or_free;

    assign accept  = in_valid && in_ready_q;
    assign or_free = !or_valid || out_ready;

    // in_ready is simply "skid register empty", kept as its own flop so it
    // never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_q       <= '0;
            sr_q       <= '0;
            or_valid   <= 1'b0;
            sr_valid   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (or_free) begin
            if (sr_valid) begin
                or_q       <= sr_q;
                or_valid   <= 1'b1;
                sr_valid   <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (accept) begin
                or_q     <= new_e;
                or_valid <= 1'b1;
            end else begin
                or_valid <= 1'b0;
            end
        end else if (accept) begin
            sr_q       <= new_e;
            sr_valid   <= 1'b1;
            in_ready_q <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid;
    assign sign1     = or_q.sign1;
    assign sign2     = or_q.sign2;
    assign mag1      = or_q.mag1;
    assign mag2      = or_q.mag2;
    assign zero1     = or_q.zero1;
    assign zero2     = or_q.zero2;
    assign nar1      = or_q.nar1;
    assign nar2      = or_q.nar2;
    assign swapped   = or_q.swapped;
    assign op_out    = or_q.op;

endmodule
